// File: rtl/pll_lock_ctrl_if.sv
// pll_lock_ctrl_if: lock-indicator/request inputs and reset/status outputs of pll_lock_ctrl
interface pll_lock_ctrl_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  modport master (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt
  );
  modport slave (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset/lock sequencer; define PLL_LOCK_CTRL_LOSS_CNT_EN to add the loss-of-lock counter
module pll_lock_ctrl #(
  parameter int RST_CYCLES   = 10,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 3
) (
  input logic            refclk,
  input logic            rst_n,
  pll_lock_ctrl_if.slave bus
);
  localparam logic [15:0] RST_END   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] STB_END   = 16'(LOCK_STABLE);
  localparam logic [19:0] TO_END    = 20'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  state_t      state, state_nx;
  logic        lock_m, lock_s;
  logic [15:0] cnt, cnt_nx;
  logic [19:0] tcnt, tcnt_nx;
  logic [3:0]  retry_nx;
  logic        run_hold;
  // release is held off for the first RUN cycle but drops on the edge that leaves RUN
  assign run_hold = state == RUN && state_nx == RUN;
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      lock_m        <= 1'b0;
      lock_s        <= 1'b0;
      state         <= RESET_PLL;
      cnt           <= '0;
      tcnt          <= '0;
      bus.retry_cnt <= '0;
      bus.pll_rst   <= 1'b1;
      bus.sys_rst_n <= 1'b0;
      bus.ready     <= 1'b0;
      bus.fail      <= 1'b0;
    end else begin
      lock_m        <= bus.pll_locked;
      lock_s        <= lock_m;
      state         <= state_nx;
      cnt           <= cnt_nx;
      tcnt          <= tcnt_nx;
      bus.retry_cnt <= retry_nx;
      bus.pll_rst   <= state_nx == RESET_PLL || state_nx == FAIL;
      bus.sys_rst_n <= run_hold;
      bus.ready     <= run_hold;
      bus.fail      <= state_nx == FAIL;
    end
  // cnt times the reset pulse and the stable window; tcnt only advances in WAIT_LOCK
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tcnt_nx  = tcnt;
    retry_nx = bus.retry_cnt;
    case (state)
      RESET_PLL:
        if (cnt == RST_END) begin
          state_nx = WAIT_LOCK;
          tcnt_nx  = '0;
        end else cnt_nx = cnt + 1'b1;
      WAIT_LOCK:
        if (lock_s) begin
          state_nx = STABLE;
          cnt_nx   = 16'd1;
        end else if (tcnt == TO_END) begin
          if (bus.retry_cnt == RETRY_MAX) state_nx = FAIL;
          else begin
            state_nx = RESET_PLL;
            cnt_nx   = '0;
            retry_nx = bus.retry_cnt + 1'b1;
          end
        end else tcnt_nx = tcnt + 1'b1;
      STABLE:
        if (!lock_s) state_nx = WAIT_LOCK;
        else if (cnt == STB_END) begin
          state_nx = RUN;
          retry_nx = '0;
        end else cnt_nx = cnt + 1'b1;
      RUN, FAIL:
        if (bus.relock_req || (state == RUN && !lock_s)) begin
          state_nx = RESET_PLL;
          cnt_nx   = '0;
          retry_nx = '0;
        end
      default: state_nx = RESET_PLL;
    endcase
  end
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) bus.loss_cnt <= '0;
    else if (state == RUN && !lock_s && bus.loss_cnt != 8'hff) bus.loss_cnt <= bus.loss_cnt + 1'b1;
`else
  assign bus.loss_cnt = '0;
`endif
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: directed scenarios checked against a cycle model and hand-computed edge numbers
module tb_pll_lock_ctrl;
  localparam int R = 4, S = 8, T = 32, M = 2;
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif
  typedef enum int {M_RST, M_WAIT, M_STB, M_RUN, M_FAIL} ph_t;
  logic refclk = 1'b0;
  logic rst_n = 1'b0;
  bit   mon = 1'b0;
  int   errors = 0;
  int   checks = 0;
  pll_lock_ctrl_if bus();
  pll_lock_ctrl #(.RST_CYCLES(R), .LOCK_STABLE(S), .LOCK_TIMEOUT(T), .MAX_RETRY(M)) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );
  always #5 refclk = ~refclk;
  function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction
  // Reference model: phase plus counts of remaining pulse cycles, waited cycles, locked streak
  ph_t ph = M_RST;
  int  left = R, waited = 0, streak = 0, retries = 0, losses = 0, run_age = 0;
  bit  q1 = 1'b0, q2 = 1'b0, l_now = 1'b0;
  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      ph = M_RST; left = R; waited = 0; streak = 0; retries = 0; losses = 0; run_age = 0;
      q1 = 1'b0; q2 = 1'b0;
    end else begin
      l_now = q2; q2 = q1; q1 = bus.pll_locked;
      case (ph)
        M_RST: begin
          left--;
          if (left == 0) begin ph = M_WAIT; waited = 0; end
        end
        M_WAIT:
          if (l_now) begin ph = M_STB; streak = 1; end
          else begin
            waited++;
            if (waited == T) begin
              if (retries < M) begin retries++; ph = M_RST; left = R; end
              else ph = M_FAIL;
            end
          end
        M_STB:
          if (!l_now) ph = M_WAIT;
          else if (streak == S) begin ph = M_RUN; run_age = 0; retries = 0; end
          else streak++;
        M_RUN:
          if (!l_now || bus.relock_req) begin
            if (!l_now && LOSS_EN && losses < 255) losses++;
            ph = M_RST; left = R; retries = 0;
          end else run_age++;
        M_FAIL:
          if (bus.relock_req) begin ph = M_RST; left = R; retries = 0; end
        default: ph = M_RST;
      endcase
    end
  end
  always @(negedge refclk) if (mon) begin
    chk("pll_rst", bus.pll_rst, ph == M_RST || ph == M_FAIL);
    chk("sys_rst_n", bus.sys_rst_n, ph == M_RUN && run_age > 0);
    chk("ready", bus.ready, ph == M_RUN && run_age > 0);
    chk("fail", bus.fail, ph == M_FAIL);
    chk("retry_cnt", bus.retry_cnt, retries);
    chk("loss_cnt", bus.loss_cnt, losses);
  end
  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask
  task automatic release_rst();
    @(negedge refclk);
    rst_n = 1'b1;
    mon = 1'b1;
    #1;
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_pll_rst"}, bus.pll_rst, 1);
    chk({tag, "_sys_rst_n"}, bus.sys_rst_n, 0);
    chk({tag, "_ready"}, bus.ready, 0);
    chk({tag, "_fail"}, bus.fail, 0);
    chk({tag, "_retry"}, bus.retry_cnt, 0);
    chk({tag, "_loss"}, bus.loss_cnt, 0);
  endtask
  initial begin
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;
    repeat (3) @(negedge refclk);
    // nominal lock, loss, relock variants, then async reset in STABLE (edges counted from release)
    release_rst();
    reset_vals("rst");
    tick(3);  chk("pulse_e3", bus.pll_rst, 1);
    tick(1);  chk("pulse_e4", bus.pll_rst, 0);
    tick(5);  bus.pll_locked = 1'b1;
    tick(11); chk("lock_e20_sys", bus.sys_rst_n, 0);
    tick(1);  chk("lock_e21_sys", bus.sys_rst_n, 1); chk("lock_e21_ready", bus.ready, 1);
    tick(4);  bus.pll_locked = 1'b0;
    tick(2);  chk("loss_e27_sys", bus.sys_rst_n, 1);
    tick(1);  chk("loss_e28_sys", bus.sys_rst_n, 0); chk("loss_e28_ready", bus.ready, 0);
    chk("loss_e28_pll_rst", bus.pll_rst, 1); chk("loss_e28_cnt", bus.loss_cnt, LOSS_EN ? 1 : 0);
    tick(3);  chk("loss_e31_pll_rst", bus.pll_rst, 1);
    tick(1);  chk("loss_e32_pll_rst", bus.pll_rst, 0);
    tick(1);  bus.relock_req = 1'b1;
    tick(1);  bus.relock_req = 1'b0; chk("wait_relock_ignored", bus.pll_rst, 0);
    bus.pll_locked = 1'b1;
    tick(12); chk("relock_e46_sys", bus.sys_rst_n, 1);
    tick(1);  bus.pll_locked = 1'b0;
    tick(2);  bus.relock_req = 1'b1;
    tick(1);  bus.relock_req = 1'b0;
    chk("both_e50_sys", bus.sys_rst_n, 0); chk("both_e50_cnt", bus.loss_cnt, LOSS_EN ? 2 : 0);
    tick(4);  chk("both_e54_pll_rst", bus.pll_rst, 0);
    bus.pll_locked = 1'b1;
    tick(12); chk("run_e66_sys", bus.sys_rst_n, 1); bus.relock_req = 1'b1;
    tick(1);  bus.relock_req = 1'b0;
    chk("rrun_e67_sys", bus.sys_rst_n, 0); chk("rrun_e67_pll_rst", bus.pll_rst, 1);
    chk("rrun_e67_cnt", bus.loss_cnt, LOSS_EN ? 2 : 0);
    tick(7);  chk("stable_e74_pll_rst", bus.pll_rst, 0);
    #2 rst_n = 1'b0;
    #1 reset_vals("async");
    bus.pll_locked = 1'b0;
    tick(2);
    // glitch in STABLE restarts the stable window
    release_rst();
    tick(4);  bus.pll_locked = 1'b1;
    tick(6);  bus.pll_locked = 1'b0;
    tick(1);  bus.pll_locked = 1'b1;
    tick(5);  chk("glitch_e16_sys", bus.sys_rst_n, 0);
    tick(6);  chk("glitch_e22_sys", bus.sys_rst_n, 0);
    tick(1);  chk("glitch_e23_sys", bus.sys_rst_n, 1);
    #2 rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    tick(2);
    // no lock: retries, FAIL at edge 108, relock_req recovery
    release_rst();
    tick(35); chk("nolock_e35_pll_rst", bus.pll_rst, 0); chk("nolock_e35_retry", bus.retry_cnt, 0);
    tick(1);  chk("nolock_e36_pll_rst", bus.pll_rst, 1); chk("nolock_e36_retry", bus.retry_cnt, 1);
    tick(36); chk("nolock_e72_retry", bus.retry_cnt, 2);
    tick(35); chk("nolock_e107_fail", bus.fail, 0);
    tick(1);  chk("nolock_e108_fail", bus.fail, 1); chk("nolock_e108_pll_rst", bus.pll_rst, 1);
    chk("nolock_e108_sys", bus.sys_rst_n, 0);
    tick(2);  bus.relock_req = 1'b1;
    tick(1);  bus.relock_req = 1'b0;
    chk("rec_e111_retry", bus.retry_cnt, 0); chk("rec_e111_fail", bus.fail, 0);
    chk("rec_e111_pll_rst", bus.pll_rst, 1);
    tick(3);  chk("rec_e114_pll_rst", bus.pll_rst, 1);
    tick(1);  chk("rec_e115_pll_rst", bus.pll_rst, 0); bus.pll_locked = 1'b1;
    tick(11); chk("rec_e126_sys", bus.sys_rst_n, 0);
    tick(1);  chk("rec_e127_sys", bus.sys_rst_n, 1); chk("rec_e127_ready", bus.ready, 1);
    // repeated losses drive loss_cnt into saturation
    for (int i = 0; i < 260; i++) begin
      bus.pll_locked = 1'b0;
      tick(3);
      bus.pll_locked = 1'b1;
      tick(15);
    end
    chk("sat_sys", bus.sys_rst_n, 1);
    chk("sat_loss", bus.loss_cnt, LOSS_EN ? 255 : 0);
    mon = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_lock_ctrl.md
PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 10: width of the PLL reset pulse, in refclk cycles (range 1..255).
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: number of consecutive locked cycles required before release (range 1..65535).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 50000: maximum WAIT_LOCK cycles per attempt (range 1..2^20-1).
REQ-004 SHALL have parameter MAX_RETRY, default 3: PLL reset re-attempts allowed after the first timeout (range 0..15).
REQ-005 SHALL have port refclk, input, 1 bit: the single free-running clock; all flops are on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port pll_locked, input, 1 bit: PLL lock indicator, asynchronous to refclk.
REQ-008 SHALL have port relock_req, input, 1 bit: synchronous single-cycle request to re-run the lock sequence.
REQ-009 SHALL have port pll_rst, output, 1 bit: active-high reset driven to the PLL.
REQ-010 SHALL have port sys_rst_n, output, 1 bit: active-low reset for the PLL-clocked logic, registered.
REQ-011 SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-012 SHALL have port fail, output, 1 bit: high only in state FAIL.
REQ-013 SHALL have port retry_cnt, output, 4 bits: number of retries used in the current sequence.
REQ-014 SHALL have port loss_cnt, output, 8 bits: loss-of-lock event count (see REQ-030).

Function
REQ-015 SHALL pass pll_locked through a 2-flop synchronizer; the output is lock_s. All decisions SHALL use only lock_s.
REQ-016 SHALL implement the states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAIL, all registered.
REQ-017 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK with the timeout counter cleared.
REQ-018 WAIT_LOCK: pll_rst=0.
  - lock_s=1 → go to STABLE, stable counter=1.
  - Timeout counter reaches LOCK_TIMEOUT and retry_cnt<MAX_RETRY → increment retry_cnt, go to RESET_PLL.
  - Timeout counter reaches LOCK_TIMEOUT and retry_cnt=MAX_RETRY → go to FAIL.
REQ-019 STABLE:
  - lock_s=0 → go back to WAIT_LOCK; the timeout counter resumes without being cleared.
  - Stable counter reaches LOCK_STABLE → go to RUN and clear retry_cnt.
REQ-020 RUN: sys_rst_n=1 and ready=1. lock_s=0 → go to RESET_PLL; sys_rst_n SHALL fall on that same edge.
REQ-021 FAIL: pll_rst=1, sys_rst_n=0, fail=1. The block stays in FAIL until relock_req or rst_n.
REQ-022 relock_req in RUN or FAIL SHALL go to RESET_PLL and clear retry_cnt.
  - relock_req SHALL be ignored in all other states.
  - relock_req together with loss of lock in RUN SHALL be handled as a single RESET_PLL entry.
REQ-023 sys_rst_n SHALL be 0 in every state other than RUN.
REQ-024 Latency: sys_rst_n SHALL rise exactly LOCK_STABLE+3 refclk edges after the first edge that samples pll_locked=1, provided lock is held and the timeout does not expire.
REQ-025 Counters SHALL never wrap. Each counter is cleared on entry to the state that uses it.

Reset
REQ-026 rst_n low SHALL asynchronously force the following values:
  - state=RESET_PLL with its cycle counter at 0
  - pll_rst=1, sys_rst_n=0, ready=0, fail=0
  - retry_cnt=0, loss_cnt=0, synchronizer flops=0
REQ-027 On rst_n release, the RESET_PLL pulse SHALL last RST_CYCLES cycles, counted from the first rising edge.
REQ-028 rst_n asserted mid-sequence SHALL abort any state immediately; no partial count is retained.

Configuration
REQ-029 Macro PLL_LOCK_CTRL_LOSS_CNT_EN SHALL select the loss-of-lock counter.
REQ-030 With PLL_LOCK_CTRL_LOSS_CNT_EN defined, loss_cnt SHALL:
  - increment by 1 on each RUN→RESET_PLL transition caused by lock_s=0;
  - saturate at 255;
  - not be cleared by relock_req.
REQ-031 With PLL_LOCK_CTRL_LOSS_CNT_EN undefined, loss_cnt SHALL be constant 0 and no counter logic SHALL exist.

Verification
Parameters for all scenarios: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2.
REQ-032 Nominal lock: pll_locked rises 10 cycles after rst_n release → pll_rst high for edges 1-4; sys_rst_n and ready rise 11 edges after pll_locked is first sampled high.
REQ-033 Glitch during STABLE: pll_locked dropped for 1 cycle after 5 stable cycles → no release; sys_rst_n rises only after 8 fresh consecutive cycles.
REQ-034 No lock: pll_locked tied 0 → 3 pll_rst pulses; retry_cnt reads 1 then 2; fail rises at edge 108 after rst_n release and pll_rst stays 1.
REQ-035 Loss of lock in RUN: pll_locked drops → sys_rst_n falls and ready falls 3 edges later; a 4-cycle pll_rst pulse follows; loss_cnt=1 (macro defined) or 0 (macro undefined).
REQ-036 Recovery: relock_req in FAIL → retry_cnt=0, a new RESET_PLL pulse, then normal lock. rst_n asserted in STABLE → all outputs return to reset values within the same cycle.
